// File: rtl/geogenius_pkg.sv
// geogenius_pkg: definitions shared by the game blocks.
//   estado_t  - state encoding of exibe_sequencia. These codes are also what
//               the hexa7seg debug display decodes, so keep them stable.
//   LED_W     - number of game LEDs.
//   max_int   - elaboration-time helper used to size counters.
package geogenius_pkg;

    localparam int LED_W = 8;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ESPERA_MEM = 4'd1,
        CAPTURA    = 4'd2,
        ACENDE     = 4'd3,
        APAGA      = 4'd4,
        FIM        = 4'd5
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if: signals between the sequencer and the rest of the game.
//   Control handshake: iniciar is a start request. It is accepted only while
//   ocupado=0, and only when parar is low. ocupado stays high for the whole
//   playback. pronto pulses for exactly one cycle when playback completes, and
//   a new iniciar is accepted at the earliest in the cycle after that pulse.
//   Memory bus: endereco is the read address. dado_memoria returns the
//   pattern one cycle later.
//   master: controller/datapath side. slave: the sequencer.
interface exibe_sequencia_if
    import geogenius_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              parar;
    logic [ADDR_W-1:0] tamanho;
    logic              dificuldade;
    logic [LED_W-1:0]  dado_memoria;
    logic [ADDR_W-1:0] endereco;
    logic [LED_W-1:0]  leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, parar, tamanho, dificuldade, dado_memoria,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, parar, tamanho, dificuldade, dado_memoria,
        output endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/temporizador_exibicao.sv
// temporizador_exibicao: loadable down-counter that times the LED on/off phases.
//   clock, reset - system clock; synchronous active-low reset (count -> 0)
//   carrega      - load valor on the next edge
//   valor        - phase length minus one
//   fim          - high during the last cycle of the phase (count == 0)
// The counter holds at zero, so fim stays high until the next load.
module temporizador_exibicao #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    output logic         fim
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carrega) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == '0);
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: replays the stored move sequence on the game LEDs.
//   clock, reset - system clock; synchronous active-low reset
//   bus (slave)  - iniciar/parar/tamanho/dificuldade in; dado_memoria from the
//                  sequence ROM; endereco, leds, ocupado, pronto, db_estado out
// Walks addresses 0..tamanho. Each entry costs 2 cycles for the memory read and
// capture, then TA lit cycles and TP dark cycles. In fast mode both times are
// halved.
module exibe_sequencia
    import geogenius_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250
) (
    input  logic clock,
    input  logic reset,
    exibe_sequencia_if.slave bus
);
    localparam int TW = $clog2(max_int(T_ACESO, T_APAGADO) + 1);

    // The timer is loaded with the length minus one, because fim is seen
    // during the final cycle of the phase.
    localparam logic [TW-1:0] TA_NORMAL = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] TA_RAPIDO = TW'(T_ACESO / 2 - 1);
    localparam logic [TW-1:0] TP_NORMAL = TW'(T_APAGADO - 1);
    localparam logic [TW-1:0] TP_RAPIDO = TW'(T_APAGADO / 2 - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] tamanho_q, tamanho_d;
    logic              rapido_q, rapido_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              carrega;
    logic [TW-1:0]     valor;
    logic              fim;

    temporizador_exibicao #(.W(TW)) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega),
        .valor   (valor),
        .fim     (fim)
    );

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        tamanho_d  = tamanho_q;
        rapido_d   = rapido_q;
        leds_d     = leds_q;
        carrega    = 1'b0;
        valor      = '0;

        case (estado_q)
            INICIAL: begin
                endereco_d = '0;
                leds_d     = '0;
                // If parar and iniciar are both high, parar wins.
                if (bus.iniciar && !bus.parar) begin
                    estado_d  = ESPERA_MEM;
                    tamanho_d = bus.tamanho;
                    rapido_d  = bus.dificuldade;
                end
            end
            ESPERA_MEM: begin
                // The ROM is reading endereco this cycle.
                estado_d = CAPTURA;
            end
            CAPTURA: begin
                estado_d = ACENDE;
                leds_d   = bus.dado_memoria;
                carrega  = 1'b1;
                valor    = rapido_q ? TA_RAPIDO : TA_NORMAL;
            end
            ACENDE: begin
                if (fim) begin
                    estado_d = APAGA;
                    leds_d   = '0;
                    carrega  = 1'b1;
                    valor    = rapido_q ? TP_RAPIDO : TP_NORMAL;
                end
            end
            APAGA: begin
                if (fim) begin
                    if (endereco_q == tamanho_q) begin
                        estado_d = FIM;
                    end else begin
                        estado_d   = ESPERA_MEM;
                        endereco_d = endereco_q + 1'b1;
                    end
                end
            end
            FIM: begin
                estado_d   = INICIAL;
                endereco_d = '0;
            end
            default: begin
                estado_d   = INICIAL;
                endereco_d = '0;
                leds_d     = '0;
            end
        endcase

        // Abort from any active state. It skips FIM, so pronto is not raised.
        if (bus.parar && (estado_q != INICIAL)) begin
            estado_d   = INICIAL;
            endereco_d = '0;
            leds_d     = '0;
            carrega    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            endereco_q <= '0;
            tamanho_q  <= '0;
            rapido_q   <= 1'b0;
            leds_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            tamanho_q  <= tamanho_d;
            rapido_q   <= rapido_d;
            leds_q     <= leds_d;
        end
    end

    assign bus.endereco  = endereco_q;
    assign bus.leds      = leds_q;
    assign bus.ocupado   = (estado_q != INICIAL);
    assign bus.pronto    = (estado_q == FIM);
    assign bus.db_estado = estado_q;
endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;
  localparam int ADDR_W    = 4;
  localparam int T_ACESO   = 4;
  localparam int T_APAGADO = 2;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [7:0] rom [16];

  exibe_sequencia_if #(.ADDR_W(ADDR_W)) bus ();

  exibe_sequencia #(
    .ADDR_W    (ADDR_W),
    .T_ACESO   (T_ACESO),
    .T_APAGADO (T_APAGADO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // sequence ROM with one cycle of read latency
  always @(posedge clock) bus.dado_memoria <= rom[bus.endereco];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int addr, input int led,
                           input bit busy, input bit done);
    check({tag, " estado"},   32'(bus.db_estado), 32'(st));
    check({tag, " endereco"}, 32'(bus.endereco),  32'(addr));
    check({tag, " leds"},     32'(bus.leds),      32'(led));
    check({tag, " ocupado"},  32'(bus.ocupado),   32'(busy));
    check({tag, " pronto"},   32'(bus.pronto),    32'(done));
  endtask

  // Reference model: the timeline is derived from the per-entry period
  // P = 2+TA+TP. Inside an entry, offset 0 is the memory wait, offset 1 is the
  // capture, the next TA cycles are lit and the rest are dark. pronto falls in
  // cycle (k+1)*P+1.
  task automatic run_seq(input string name, input int k, input bit fast, input int abort_n,
                         input bit use_reset, input bit disturb);
    int ta, tp, per, last, e, o, st, led;
    ta   = fast ? T_ACESO / 2 : T_ACESO;
    tp   = fast ? T_APAGADO / 2 : T_APAGADO;
    per  = 2 + ta + tp;
    last = (k + 1) * per + 1;
    @(negedge clock);
    bus.iniciar     = 1'b1;
    bus.tamanho     = 4'(k);
    bus.dificuldade = fast;
    for (int n = 1; n <= last + 2; n++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      if (abort_n != 0 && n == abort_n + 1) begin
        check_all($sformatf("%s abort c%0d", name, n), 0, 0, 0, 1'b0, 1'b0);
        bus.parar = 1'b0;
        reset     = 1'b1;
        break;
      end
      if (n < last) begin
        e   = (n - 1) / per;
        o   = (n - 1) % per;
        st  = (o == 0) ? 1 : (o == 1) ? 2 : (o < 2 + ta) ? 3 : 4;
        led = (st == 3) ? int'(rom[e]) : 0;
        check_all($sformatf("%s c%0d", name, n), st, e, led, 1'b1, 1'b0);
      end else if (n == last) begin
        check_all($sformatf("%s c%0d", name, n), 5, k, 0, 1'b1, 1'b1);
      end else begin
        check_all($sformatf("%s c%0d", name, n), 0, 0, 0, 1'b0, 1'b0);
      end
      if (disturb) begin
        if (n == 2) bus.tamanho = 4'($urandom_range(0, 15));
        if (n == 3 + ta) bus.iniciar = 1'b1;
      end
      if (n == abort_n) begin
        if (use_reset) reset = 1'b0;
        else bus.parar = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset           = 1'b0;
    bus.iniciar     = 1'b0;
    bus.parar       = 1'b0;
    bus.tamanho     = '0;
    bus.dificuldade = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h01;
    rom[1] = 8'h04;
    rom[2] = 8'h80;

    repeat (3) @(negedge clock);
    check_all("reset", 0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;

    run_seq("normal", 2, 1'b0, 0, 1'b0, 1'b0);
    run_seq("fast", 2, 1'b1, 0, 1'b0, 1'b0);
    run_seq("single", 0, 1'b0, 0, 1'b0, 1'b0);
    // second ACENDE of normal mode begins at cycle P+3 = 11
    run_seq("parar", 2, 1'b0, 11, 1'b0, 1'b0);
    run_seq("disturb", 2, 1'b0, 0, 1'b0, 1'b1);
    run_seq("midreset", 2, 1'b0, 10, 1'b1, 1'b0);

    // parar and iniciar together while idle: stays idle
    @(negedge clock);
    bus.iniciar = 1'b1;
    bus.parar   = 1'b1;
    bus.tamanho = 4'd3;
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    check_all("both_idle", 0, 0, 0, 1'b0, 1'b0);
    @(negedge clock);
    check_all("both_idle2", 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    run_seq("full", 15, 1'b0, 0, 1'b0, 1'b0);
    run_seq("full_fast", 15, 1'b1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      run_seq($sformatf("rand%0d", r), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
